// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result path.
//   N_DEF / D_W_ACC_DEF : default array dimension and accumulator word width
//   CNT_W / IDX_W       : lane counter and tile output index widths for the defaults
//   collector_state_e   : drain collector FSM state
package systolic_pkg;

    localparam int N_DEF       = 4;
    localparam int D_W_ACC_DEF = 64;
    localparam int CNT_W       = $clog2(N_DEF + 1);
    localparam int IDX_W       = $clog2(N_DEF * N_DEF);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } collector_state_e;

endpackage

// File: rtl/drain_col_capture.sv
// One column lane of the drain collector.
// Tracks how many result words have arrived on the lane and produces the
// tile write strobe and row address for the next word. Chain order is fixed:
// the k-th word on a lane belongs to row N-1-k.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   collect_i    : collector is in COLLECT (words may be stored)
//   clear_i      : tile finished; return the counter to zero
//   valid_i      : lane word valid
//   we_o         : store the lane word this cycle
//   row_o        : tile row for the word being stored
//   full_nxt_o   : lane will hold N words after this clock edge
//   ovf_o        : lane word dropped this cycle (lane full or not collecting)
module drain_col_capture #(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N + 1),
    parameter int ROW_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             collect_i,
    input  logic             clear_i,
    input  logic             valid_i,
    output logic             we_o,
    output logic [ROW_W-1:0] row_o,
    output logic             full_nxt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             full;

    assign full  = (cnt_q == CNT_W'(N));
    assign we_o  = collect_i & valid_i & ~full;
    // Any valid word that is not stored is lost.
    assign ovf_o = valid_i & ~we_o;
    // Only meaningful while cnt_q < N, so the truncation is lossless there.
    assign row_o = ROW_W'(N - 1) - ROW_W'(cnt_q);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (we_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign full_nxt_o = (cnt_d == CNT_W'(N));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/systolic_drain_collector.sv
// Receiving end of the PE result shift chain. Collects N words per column,
// places them in an NxN tile (row-major), then streams the tile out.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   col_valid     : per-column word valid (bit c = column c)
//   col_data      : per-column word, column c at [c*D_W_ACC +: D_W_ACC]
//   m_valid/m_ready/m_data/m_last : output stream
//   busy          : high while draining
//   err_overflow  : sticky, a result word was dropped; cleared only by rst
//   dbg_state_o   : current FSM state
// Output handshake: a word transfers on a cycle where m_valid & m_ready are
// both high. While m_valid is high and m_ready is low, m_valid, m_data and
// m_last are held unchanged. m_valid never drops without a transfer.
module systolic_drain_collector
    import systolic_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int D_W_ACC = D_W_ACC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         col_valid,
    input  logic [N*D_W_ACC-1:0] col_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [D_W_ACC-1:0]   m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 err_overflow,
    output collector_state_e     dbg_state_o
);

    localparam int ROW_W    = $clog2(N);
    localparam int IDX_BITS = $clog2(N * N);

    collector_state_e      state_q;
    logic [IDX_BITS-1:0]   idx_q;
    logic                  m_valid_q;
    logic [D_W_ACC-1:0]    m_data_q;
    logic                  m_last_q;
    logic                  err_q;

    logic [D_W_ACC-1:0]    tile_q [N*N];
    logic [D_W_ACC-1:0]    tile_d [N*N];

    logic [N-1:0]          lane_we;
    logic [N-1:0]          lane_full_nxt;
    logic [N-1:0]          lane_ovf;
    logic [ROW_W-1:0]      lane_row [N];

    logic                  collect;
    logic                  handshake;
    logic                  final_hs;
    logic [IDX_BITS-1:0]   idx_nxt;
    logic [IDX_BITS-1:0]   rd_sel;
    logic [D_W_ACC-1:0]    rd_data;

    assign collect   = (state_q == COLLECT);
    assign handshake = m_valid_q & m_ready;
    assign final_hs  = (state_q == DRAIN) & handshake & (idx_q == IDX_BITS'(N * N - 1));
    assign idx_nxt   = idx_q + 1'b1;

    for (genvar c = 0; c < N; c++) begin : g_lane
        drain_col_capture #(
            .N (N)
        ) u_cap (
            .clk        (clk),
            .rst        (rst),
            .collect_i  (collect),
            .clear_i    (final_hs),
            .valid_i    (col_valid[c]),
            .we_o       (lane_we[c]),
            .row_o      (lane_row[c]),
            .full_nxt_o (lane_full_nxt[c]),
            .ovf_o      (lane_ovf[c])
        );
    end

    // Tile next-state: one write port per column.
    always_comb begin
        tile_d = tile_q;
        for (int c = 0; c < N; c++) begin
            if (lane_we[c]) begin
                tile_d[int'(lane_row[c]) * N + c] = col_data[c*D_W_ACC +: D_W_ACC];
            end
        end
    end

    // Reading from tile_d lets the first output word be loaded on the same
    // edge that stores the last captured word.
    assign rd_sel  = collect ? '0 : idx_nxt;
    assign rd_data = tile_d[rd_sel];

    always_ff @(posedge clk) begin
        tile_q <= tile_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (|lane_ovf) begin
                err_q <= 1'b1;
            end
            case (state_q)
                COLLECT: begin
                    if (&lane_full_nxt) begin
                        state_q   <= DRAIN;
                        idx_q     <= '0;
                        m_valid_q <= 1'b1;
                        m_data_q  <= rd_data;
                        m_last_q  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        if (final_hs) begin
                            state_q   <= COLLECT;
                            idx_q     <= '0;
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                        end else begin
                            idx_q    <= idx_nxt;
                            m_data_q <= rd_data;
                            m_last_q <= (idx_nxt == IDX_BITS'(N * N - 1));
                        end
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_last       = m_last_q;
    assign busy         = (state_q == DRAIN);
    assign err_overflow = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_systolic_drain_collector.sv
// Directed bench for systolic_drain_collector (N=4, 64-bit words).
module tb_systolic_drain_collector;
    import systolic_pkg::*;

    localparam int N = 4;
    localparam int W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     col_valid;
    logic [N*W-1:0]   col_data;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data;
    logic             m_last;
    logic             busy;
    logic             err_overflow;
    collector_state_e dbg_state;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    // Clock / reset
    always #5 clk = ~clk;

    systolic_drain_collector #(
        .N       (N),
        .D_W_ACC (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .col_valid    (col_valid),
        .col_data     (col_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .err_overflow (err_overflow),
        .dbg_state_o  (dbg_state)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected tile, row-major: tile[r][c] = word k=N-1-r of column c.
    task automatic push_tile(input logic [W-1:0] base);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                exp_q.push_back(base + W'(100 * c + (N - 1 - r)));
            end
        end
    endtask

    task automatic load_aligned(input logic [W-1:0] base, input string tag);
        for (int k = 0; k < N; k++) begin
            col_valid = '1;
            for (int c = 0; c < N; c++) begin
                col_data[c*W +: W] = base + W'(100 * c + k);
            end
            chk({tag, "_busy_collect"}, W'(busy), W'(0));
            if (k == N - 1) begin
                chk({tag, "_valid_before_last"}, W'(m_valid), W'(0));
            end
            tick();
        end
        col_valid = '0;
        chk({tag, "_first_valid"}, W'(m_valid), W'(1));
        chk({tag, "_busy_drain"}, W'(busy), W'(1));
    endtask

    // Drains n words. mode 0: m_ready held high; mode 1: m_ready 1,0,0,1,...
    task automatic drain(input int n, input int mode, input string tag);
        int hs = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [W-1:0] held_d = '0;
        logic held_l = 1'b0;
        logic [W-1:0] e;
        while (hs < n && cyc < 400) begin
            m_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            chk({tag, "_m_valid"}, W'(m_valid), W'(1));
            chk({tag, "_busy"}, W'(busy), W'(1));
            if (m_valid) begin
                if (stalled) begin
                    chk({tag, "_stall_data"}, m_data, held_d);
                    chk({tag, "_stall_last"}, W'(m_last), W'(held_l));
                end
                if (m_ready) begin
                    chk({tag, "_q_empty"}, W'(exp_q.size() == 0), W'(0));
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    chk({tag, "_data"}, m_data, e);
                    chk({tag, "_last"}, W'(m_last), W'(hs == N * N - 1));
                    hs++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = m_data;
                    held_l  = m_last;
                end
            end
            tick();
            cyc++;
        end
        chk({tag, "_handshakes"}, W'(hs), W'(n));
        if (n == N * N) begin
            chk({tag, "_valid_after"}, W'(m_valid), W'(0));
            chk({tag, "_last_after"}, W'(m_last), W'(0));
            chk({tag, "_busy_after"}, W'(busy), W'(0));
            chk({tag, "_q_left"}, W'(exp_q.size()), W'(0));
        end
        m_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        col_valid = '0;
        col_data  = '0;
        m_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_m_valid", W'(m_valid), W'(0));
        chk("rst_m_last", W'(m_last), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_err", W'(err_overflow), W'(0));
        chk("rst_m_data", m_data, W'(0));
        chk("rst_state", W'(dbg_state), W'(COLLECT));
        rst = 1'b0;
        tick();

        // Tile A: all lanes aligned, m_ready high
        push_tile(W'(0));
        load_aligned(W'(0), "tileA");
        chk("tileA_state", W'(dbg_state), W'(DRAIN));
        drain(N * N, 0, "tileA");

        // Tile B: back-to-back, starts the cycle after the final handshake; stalled drain
        push_tile(W'(64'h0000_B000_0000_0000));
        load_aligned(W'(64'h0000_B000_0000_0000), "tileB");
        drain(N * N, 1, "tileB");

        // Tile C: skewed lanes, column c starts at cycle c, every other cycle
        push_tile(W'(64'h0C00));
        for (int cyc = 0; cyc < 10; cyc++) begin
            col_valid = '0;
            for (int c = 0; c < N; c++) begin
                if (cyc >= c && ((cyc - c) % 2 == 0) && ((cyc - c) / 2 < N)) begin
                    col_valid[c]       = 1'b1;
                    col_data[c*W +: W] = W'(64'h0C00) + W'(100 * c + (cyc - c) / 2);
                end
            end
            chk("tileC_busy_collect", W'(busy), W'(0));
            chk("tileC_no_valid", W'(m_valid), W'(0));
            tick();
        end
        col_valid = '0;
        chk("tileC_first_valid", W'(m_valid), W'(1));
        chk("tileC_err", W'(err_overflow), W'(0));
        drain(N * N, 0, "tileC");
        chk("tileC_err_after", W'(err_overflow), W'(0));

        // Tile D: 5th word on column 1 while column 0 still collecting
        push_tile(W'(64'h0D00));
        for (int cyc = 0; cyc < 6; cyc++) begin
            col_valid = '0;
            if (cyc >= 2) begin
                col_valid[0]   = 1'b1;
                col_data[0 +: W] = W'(64'h0D00) + W'(cyc - 2);
            end
            if (cyc <= 4) begin
                col_valid[1]     = 1'b1;
                col_data[W +: W] = (cyc == 4) ? W'(64'hDEAD) : W'(64'h0D00) + W'(100 + cyc);
            end
            if (cyc <= 3) begin
                col_valid[2]       = 1'b1;
                col_valid[3]       = 1'b1;
                col_data[2*W +: W] = W'(64'h0D00) + W'(200 + cyc);
                col_data[3*W +: W] = W'(64'h0D00) + W'(300 + cyc);
            end
            if (cyc == 4) begin
                chk("ovf_err_before", W'(err_overflow), W'(0));
            end
            if (cyc == 5) begin
                chk("ovf_err_set", W'(err_overflow), W'(1));
                chk("ovf_still_collect", W'(busy), W'(0));
            end
            tick();
        end
        col_valid = '0;
        chk("tileD_first_valid", W'(m_valid), W'(1));
        // Word on column 0 during DRAIN, with the output stalled
        m_ready   = 1'b0;
        col_valid = 4'b0001;
        col_data[0 +: W] = W'(64'hBAD0);
        tick();
        col_valid = '0;
        chk("drain_drop_err", W'(err_overflow), W'(1));
        chk("drain_drop_valid", W'(m_valid), W'(1));
        chk("drain_drop_head", m_data, exp_q[0]);
        drain(N * N, 0, "tileD");
        chk("tileD_err_sticky", W'(err_overflow), W'(1));

        // Tile E: reset after 8 of 16 words drained
        push_tile(W'(64'h0E00));
        load_aligned(W'(64'h0E00), "tileE");
        drain(8, 0, "tileE");
        chk("tileE_err_before_rst", W'(err_overflow), W'(1));
        exp_q.delete();
        rst = 1'b1;
        tick();
        chk("midrst_valid", W'(m_valid), W'(0));
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_err", W'(err_overflow), W'(0));
        chk("midrst_last", W'(m_last), W'(0));
        chk("midrst_data", m_data, W'(0));
        rst = 1'b0;
        tick();

        // Tile F: fresh tile after reset, stalled drain from index 0
        push_tile(W'(64'h0F00));
        load_aligned(W'(64'h0F00), "tileF");
        drain(N * N, 1, "tileF");
        chk("tileF_err", W'(err_overflow), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
